// File: rtl/pe_writeback.sv
// pe_writeback: result writeback stage between the PE core and the PE
// register file.
//
// Captures each valid PE result (data + destination tag) into a small
// in-order FIFO and drains one entry per cycle into the register file's
// single write port. A host/debug write request takes the port ahead of
// the drain for that cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   res_data/res_dst  PE result and its destination register
//   res_valid         result valid this cycle
//   wb_ready          FIFO can accept a result (count < DEPTH)
//   ext_wr_en/addr/data  host write request, highest priority
//   rf_wr_en/addr/data   registered register-file write port
//   pending_mask      one bit per register with a queued or in-flight drain
//   fifo_count        current FIFO occupancy
//   overflow          sticky: a result arrived while full and was dropped
//   ovf_clr           synchronous clear of overflow
module pe_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   res_data,
  input  logic [ADDR_WIDTH-1:0]   res_dst,
  input  logic                    res_valid,
  output logic                    wb_ready,
  input  logic                    ext_wr_en,
  input  logic [ADDR_WIDTH-1:0]   ext_wr_addr,
  input  logic [DATA_WIDTH-1:0]   ext_wr_data,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic [NUM_REGS-1:0]     pending_mask,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]       CNT_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0]       PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] dst_mem_q  [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  rf_wr_en_q;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_q;
  logic [DATA_WIDTH-1:0] rf_wr_data_q;
  logic                  drain_q;     // current output-stage write came from the FIFO
  logic                  overflow_q;
  logic                  not_full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic [NUM_REGS-1:0]   pending_s;

  // Push/pop decisions; the full check uses the pre-edge count so a pop in
  // the same cycle never makes room for a push into a full FIFO.
  always_comb begin
    not_full_s = (count_q < DEPTH_C);
    push_s     = res_valid & not_full_s;
    drop_s     = res_valid & ~not_full_s;
    pop_s      = ~ext_wr_en & (count_q != {CW{1'b0}});
  end

  // Next occupancy
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= {DATA_WIDTH{1'b0}};
        dst_mem_q[i]  <= {ADDR_WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        data_mem_q[wr_ptr_q] <= res_data;
        dst_mem_q[wr_ptr_q]  <= res_dst;
        wr_ptr_q             <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Register-file output stage: host write first, then FIFO drain, else idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= {ADDR_WIDTH{1'b0}};
      rf_wr_data_q <= {DATA_WIDTH{1'b0}};
      drain_q      <= 1'b0;
    end else if (ext_wr_en) begin
      rf_wr_en_q   <= 1'b1;
      rf_wr_addr_q <= ext_wr_addr;
      rf_wr_data_q <= ext_wr_data;
      drain_q      <= 1'b0;
    end else if (pop_s) begin
      rf_wr_en_q   <= 1'b1;
      rf_wr_addr_q <= dst_mem_q[rd_ptr_q];
      rf_wr_data_q <= data_mem_q[rd_ptr_q];
      drain_q      <= 1'b1;
    end else begin
      // addr/data deliberately hold their last value
      rf_wr_en_q   <= 1'b0;
      drain_q      <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  // Pending mask: slot i is live when its distance from the read pointer
  // (modulo DEPTH) is below the occupancy.
  always_comb begin
    pending_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q) begin
        pending_s = pending_s | (REG_ONE << dst_mem_q[i]);
      end else begin
        pending_s = pending_s;
      end
    end
    if (rf_wr_en_q && drain_q) begin
      pending_s = pending_s | (REG_ONE << rf_wr_addr_q);
    end else begin
      pending_s = pending_s;
    end
  end

  assign wb_ready     = not_full_s;
  assign rf_wr_en     = rf_wr_en_q;
  assign rf_wr_addr   = rf_wr_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign pending_mask = pending_s;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pe_writeback.sv
module tb_pe_writeback;

  logic        clk;
  logic        rst_n;
  logic [31:0] res_data;
  logic [4:0]  res_dst;
  logic        res_valid;
  logic        wb_ready;
  logic        ext_wr_en;
  logic [4:0]  ext_wr_addr;
  logic [31:0] ext_wr_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr;

  pe_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_data(res_data), .res_dst(res_dst), .res_valid(res_valid),
    .wb_ready(wb_ready),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of pending results plus the output stage
  typedef struct { logic [4:0] dst; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic        m_en, m_drain, m_ovf;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  logic [36:0] wlog[$];   // {addr, data} of every observed rf write
  logic [36:0] wexp[$];

  typedef struct {
    logic rv; logic [4:0] rd; logic [31:0] rdat;
    logic ee; logic [4:0] ea; logic [31:0] ed; logic oc;
    logic en; logic [4:0] addr; logic [31:0] data; logic [2:0] cnt; logic [31:0] pend;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_drain = 1'b0; m_ovf = 1'b0; m_addr = 5'd0; m_data = 32'd0;
  endtask

  task automatic compare_model();
    logic [31:0] pm;
    pm = 32'd0;
    foreach (mq[k]) pm = pm | (32'd1 << mq[k].dst);
    if (m_en && m_drain) pm = pm | (32'd1 << m_addr);
    check("m_rf_wr_en", rf_wr_en, m_en);
    check("m_rf_wr_addr", rf_wr_addr, m_addr);
    check("m_rf_wr_data", rf_wr_data, m_data);
    check("m_fifo_count", fifo_count, mq.size());
    check("m_overflow", overflow, m_ovf);
    check("m_pending", pending_mask, pm);
    check("m_wb_ready", wb_ready, (mq.size() < 4) ? 1 : 0);
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare after it
  task automatic step(input logic rv, input logic [4:0] rd, input logic [31:0] rdat,
                      input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                      input logic oc);
    bit   full;
    ent_t e;
    res_valid = rv; res_dst = rd; res_data = rdat;
    ext_wr_en = ee; ext_wr_addr = ea; ext_wr_data = ed; ovf_clr = oc;
    @(posedge clk);
    full = (mq.size() >= 4);
    if (ee) begin
      m_en = 1'b1; m_addr = ea; m_data = ed; m_drain = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_en = 1'b1; m_addr = e.dst; m_data = e.data; m_drain = 1'b1;
    end else begin
      m_en = 1'b0; m_drain = 1'b0;
    end
    if (rv && !full) begin
      e.dst = rd; e.data = rdat;
      mq.push_back(e);
    end
    if (rv && full) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    #1;
    compare_model();
    if (rf_wr_en) wlog.push_back({rf_wr_addr, rf_wr_data});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic check_log(input string nm);
    check({nm, "_len"}, wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++)
      check(nm, wlog[i], wexp[i]);
  endtask

  initial begin
    // Single-result and same-address-ordering vectors
    vt[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 5'd0, 32'd0,        3'd1, 32'h0000_0008};
    vt[1] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 3'd0, 32'h0000_0008};
    vt[2] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 3'd0, 32'h0000_0000};
    vt[3] = '{1'b1, 5'd5, 32'h11,       1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 3'd1, 32'h0000_0020};
    vt[4] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd5, 32'h22,   1'b0, 1'b1, 5'd5, 32'h22,       3'd1, 32'h0000_0020};
    vt[5] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 1'b1, 5'd5, 32'h11,       3'd0, 32'h0000_0020};
    vt[6] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 5'd5, 32'h11,       3'd0, 32'h0000_0000};

    rst_n = 1'b0; res_valid = 1'b0; res_dst = 5'd0; res_data = 32'd0;
    ext_wr_en = 1'b0; ext_wr_addr = 5'd0; ext_wr_data = 32'd0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_rf_wr_addr", rf_wr_addr, 5'd0);
    check("rst_rf_wr_data", rf_wr_data, 32'd0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pending", pending_mask, 32'd0);
    check("rst_wb_ready", wb_ready, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      step(vt[i].rv, vt[i].rd, vt[i].rdat, vt[i].ee, vt[i].ea, vt[i].ed, vt[i].oc);
      check("vec_en", rf_wr_en, vt[i].en);
      check("vec_addr", rf_wr_addr, vt[i].addr);
      check("vec_data", rf_wr_data, vt[i].data);
      check("vec_count", fifo_count, vt[i].cnt);
      check("vec_pend", pending_mask, vt[i].pend);
    end

    // Burst under sustained ext priority
    wlog.delete(); wexp.delete();
    for (int k = 0; k < 6; k++) begin
      step(k < 4, 5'(k + 1), 32'hA0 + k, 1'b1, 5'd9, 32'h900 + k, 1'b0);
      if (k == 3) check("burst_wb_ready", wb_ready, 1'b0);
      wexp.push_back({5'd9, 32'h900 + k});
    end
    for (int k = 0; k < 4; k++) wexp.push_back({5'(k + 1), 32'hA0 + k});
    idle(6);
    check_log("burst_log");
    check("burst_count", fifo_count, 3'd0);

    // Overflow: fifth result dropped while ext holds the port
    wlog.delete(); wexp.delete();
    for (int k = 0; k < 6; k++) begin
      step(k < 5, 5'(10 + k), 32'h100 + k, 1'b1, 5'd20, 32'hE0 + k, 1'b0);
      if (k == 4) check("ovf_set", overflow, 1'b1);
      wexp.push_back({5'd20, 32'hE0 + k});
    end
    for (int k = 0; k < 4; k++) wexp.push_back({5'(10 + k), 32'h100 + k});
    idle(6);
    check_log("ovf_log");
    check("ovf_sticky", overflow, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    check("ovf_clr", overflow, 1'b0);

    // Continuous stream: enqueue and drain every cycle
    wlog.delete(); wexp.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'(i % 32), 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
      check("stream_count_le1", (fifo_count <= 3'd1), 1'b1);
      check("stream_wb_ready", wb_ready, 1'b1);
      wexp.push_back({5'(i % 32), 32'(i)});
    end
    idle(3);
    check_log("stream_log");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 2), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 1));
    end
    idle(8);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) step(1'b1, 5'(k + 1), 32'h300 + k, 1'b1, 5'd7, 32'h70, 1'b0);
    res_valid = 1'b0; ext_wr_en = 1'b0; ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_en", rf_wr_en, 1'b0);
    check("mid_rst_addr", rf_wr_addr, 5'd0);
    check("mid_rst_data", rf_wr_data, 32'd0);
    check("mid_rst_count", fifo_count, 3'd0);
    check("mid_rst_pend", pending_mask, 32'd0);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_ready", wb_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wlog.delete();
    idle(6);
    check("post_rst_writes", wlog.size(), 0);
    check("post_rst_count", fifo_count, 3'd0);
    check("post_rst_pend", pending_mask, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_writeback.md
Name: pe_writeback

Overview:
- Result writeback stage directly downstream of the PE core.
- Captures each valid PE result with its destination register tag and buffers it in a small in-order FIFO.
- Drains one entry per cycle into the PE register file's single write port. A host/debug write request has priority over drain on that port.
- Exports a backpressure ready signal and a pending-write mask, so the issue side can stall on full and detect RAW hazards.

Parameters:
- DATA_WIDTH, 32, width of result and register data
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers; width of pending_mask
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- res_data  in  DATA_WIDTH  result from PE core
- res_dst  in  ADDR_WIDTH  destination register of res_data
- res_valid  in  1  res_data/res_dst valid this cycle
- wb_ready  out  1  FIFO can accept (count < DEPTH); combinational from count
- ext_wr_en  in  1  host write request; wins the port this cycle
- ext_wr_addr  in  ADDR_WIDTH  host write address
- ext_wr_data  in  DATA_WIDTH  host write data
- rf_wr_en  out  1  register file write enable (registered)
- rf_wr_addr  out  ADDR_WIDTH  register file write address (registered)
- rf_wr_data  out  DATA_WIDTH  register file write data (registered)
- pending_mask  out  NUM_REGS  bit i=1: a write to reg i is queued or in output stage
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a result arrived while full and was dropped
- ovf_clr  in  1  clears overflow (synchronous)

Behaviour:
- Reset (async assert, sync release in effect):
  - FIFO empty, pointers 0, fifo_count=0.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - overflow=0, pending_mask=0, wb_ready=1.
  - Reset mid-operation discards all queued entries; no write is issued after reset asserts.
- Enqueue at edge if res_valid && count<DEPTH. The full check uses the pre-edge count:
  - An enqueue while full is rejected, even if a pop occurs in the same cycle.
  - The rejected result is dropped and overflow sets at that edge.
- Output stage, evaluated each cycle (registered, loaded at edge), in priority order:
  - ext_wr_en=1: load ext_wr_addr/ext_wr_data, rf_wr_en=1; FIFO holds.
  - Else if FIFO non-empty: pop the head, load its dst/data, rf_wr_en=1.
  - Else: rf_wr_en=0; addr/data hold their previous value.
- Simultaneous enqueue and pop (not full): count unchanged, both pointers advance.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap modulo DEPTH; occupancy is tracked by count.
- Latency:
  - res_valid in cycle N into an empty FIFO with no ext write gives rf_wr_en=1 in cycle N+2.
  - Each ext_wr_en cycle adds one cycle of delay to every queued entry.
- Ordering: strict FIFO order among PE results.
  - An ext write and a queued entry to the same address: the ext write lands first, the queued entry later overwrites it.
- No special casing of address 0; every address is written as presented.
- pending_mask is combinational: OR of one-hot(dst) over all valid FIFO entries, plus one-hot(rf_wr_addr) when rf_wr_en=1 and that write is a FIFO drain. Ext writes do not set pending bits.
- overflow:
  - Set on a dropped enqueue.
  - Cleared by ovf_clr when no drop occurs that cycle; a drop in the same cycle as ovf_clr wins, so overflow stays 1.
- fifo_count is never greater than DEPTH and never below 0; a pop is never attempted when empty.

Test Plan:
- Single result:
  - Stimulus: res_valid=1, res_dst=3, res_data=0xDEADBEEF in cycle 0; no ext writes.
  - Required: rf_wr_en=1, rf_wr_addr=3, rf_wr_data=0xDEADBEEF in cycle 2 only.
  - Required: pending_mask bit 3 high in cycles 1–2, low in cycle 3.
- Burst with sustained ext priority:
  - Stimulus: 4 results, dst 1,2,3,4, on consecutive cycles while ext_wr_en=1 (addr 9) is held for 6 cycles.
  - Required: wb_ready=0 after the fourth enqueue.
  - Required: 6 writes to r9, then r1..r4 in order; fifo_count returns to 0.
- Overflow:
  - Stimulus: 5 back-to-back results with ext_wr_en held high.
  - Required: the fifth result is dropped and overflow=1; entries 1–4 are written later in order.
  - Required: ovf_clr pulse gives overflow=0 next cycle.
- Concurrent enqueue and drain:
  - Stimulus: a continuous stream of 20 results, dst = i mod 32, data = i.
  - Required: fifo_count stays at or below 1 and wb_ready stays 1.
  - Required: all 20 writes appear in order with data = i; pointers wrap correctly.
- Same-address ordering:
  - Stimulus: enqueue dst 5 = 0x11 in cycle 0, then ext write r5 = 0x22 in cycle 1.
  - Required: rf writes appear as r5=0x22 then r5=0x11.
- Reset mid-operation:
  - Stimulus: 3 entries queued, then rst_n=0 for 2 cycles.
  - Required: all outputs are at reset values immediately.
  - Required: no rf_wr_en pulse after release; fifo_count=0; pending_mask=0.
